// File: rtl/quad_latch_pkg.sv
// Shared types and defaults for the quad latch scheduler.
// Used by the top level and by the testbench.
package quad_latch_pkg;

    localparam int unsigned CNT_W         = 4;
    localparam int unsigned PULSE_LEN_DEF = 2;
    localparam int unsigned CLR_LEN_DEF   = 2;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/quad_latch_scheduler_if.sv
// Request/acknowledge handshake and latch-bank pins of the quad latch scheduler.
// The requester side uses the master modport; the scheduler uses the slave modport.
interface quad_latch_scheduler_if;

    logic [1:0] REQ;
    logic [3:0] DATA0;
    logic [3:0] DATA1;
    logic       CLR_REQ;
    logic [1:0] ACK;
    logic       CLR_ACK;
    logic       LATCH_CLK;
    logic       LATCH_CLR_N;
    logic [3:0] LATCH_D;
    logic [3:0] SHADOW_Q;
    logic       BUSY;

    modport master (
        output REQ, DATA0, DATA1, CLR_REQ,
        input  ACK, CLR_ACK, LATCH_CLK, LATCH_CLR_N, LATCH_D, SHADOW_Q, BUSY
    );

    modport slave (
        input  REQ, DATA0, DATA1, CLR_REQ,
        output ACK, CLR_ACK, LATCH_CLK, LATCH_CLR_N, LATCH_D, SHADOW_Q, BUSY
    );

endinterface

// File: rtl/quad_latch_scheduler_rr_arb2.sv
// Two-way round-robin arbiter with a registered last-grant bit.
// On a tie the requester not granted last wins; last-grant resets to 1.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic       gnt
);

    logic last_q;
    logic last_d;

    always_comb begin
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last_q;
            default: gnt = 1'b0;
        endcase
        last_d = update ? gnt : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/quad_latch_scheduler.sv
// Sequences loads and clears of an external quad D-FF bank for two requesters.
// All bank pins and handshake outputs come straight from flops.
module quad_latch_scheduler
    import quad_latch_pkg::*;
#(
    parameter int unsigned PULSE_LEN = PULSE_LEN_DEF,
    parameter int unsigned CLR_LEN   = CLR_LEN_DEF
) (
    input logic                   CLK_DRV,
    input logic                   RESET,
    quad_latch_scheduler_if.slave bus
);

    state_e     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic       latch_clk_q, latch_clk_d;
    logic       latch_clr_n_q, latch_clr_n_d;
    logic [3:0] latch_d_q, latch_d_d;
    logic [3:0] shadow_q, shadow_d;
    logic [1:0] ack_q, ack_d;
    logic       clr_ack_q, clr_ack_d;
    logic       busy_q, busy_d;
    logic       clr_pend_q, clr_pend_d;
    logic       grant_q, grant_d;
    logic       arb_gnt;
    logic       arb_update;

    rr_arb2 u_arb (
        .clk    (CLK_DRV),
        .rst    (RESET),
        .req    (bus.REQ),
        .update (arb_update),
        .gnt    (arb_gnt)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        latch_clk_d   = 1'b0;
        latch_clr_n_d = 1'b1;
        latch_d_d     = latch_d_q;
        shadow_d      = shadow_q;
        ack_d         = '0;
        clr_ack_d     = 1'b0;
        clr_pend_d    = clr_pend_q;
        grant_d       = grant_q;
        arb_update    = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                latch_clr_n_d = 1'b0;
                if (cnt_q <= cnt_t'(1)) begin
                    // clr_pend_q separates a requested clear from the power-on clear
                    state_d       = ST_IDLE;
                    latch_clr_n_d = 1'b1;
                    shadow_d      = '0;
                    clr_ack_d     = clr_pend_q;
                    clr_pend_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_IDLE: begin
                if (bus.CLR_REQ) begin
                    state_d       = ST_CLEAR;
                    cnt_d         = cnt_t'(CLR_LEN);
                    latch_clr_n_d = 1'b0;
                    clr_pend_d    = 1'b1;
                end else if (|bus.REQ) begin
                    state_d    = ST_SETUP;
                    grant_d    = arb_gnt;
                    latch_d_d  = arb_gnt ? bus.DATA1 : bus.DATA0;
                    arb_update = 1'b1;
                end
            end
            ST_SETUP: begin
                state_d     = ST_PULSE;
                cnt_d       = cnt_t'(PULSE_LEN);
                latch_clk_d = 1'b1;
                shadow_d    = latch_d_q;
            end
            ST_PULSE: begin
                if (cnt_q <= cnt_t'(1)) begin
                    state_d        = ST_HOLD;
                    ack_d[grant_q] = 1'b1;
                end else begin
                    latch_clk_d = 1'b1;
                    cnt_d       = cnt_q - cnt_t'(1);
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d       = ST_CLEAR;
                cnt_d         = cnt_t'(CLR_LEN);
                latch_clr_n_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK_DRV) begin
        if (RESET) begin
            state_q       <= ST_CLEAR;
            cnt_q         <= cnt_t'(CLR_LEN);
            latch_clk_q   <= 1'b0;
            latch_clr_n_q <= 1'b0;
            latch_d_q     <= '0;
            shadow_q      <= '0;
            ack_q         <= '0;
            clr_ack_q     <= 1'b0;
            busy_q        <= 1'b1;
            clr_pend_q    <= 1'b0;
            grant_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            latch_clk_q   <= latch_clk_d;
            latch_clr_n_q <= latch_clr_n_d;
            latch_d_q     <= latch_d_d;
            shadow_q      <= shadow_d;
            ack_q         <= ack_d;
            clr_ack_q     <= clr_ack_d;
            busy_q        <= busy_d;
            clr_pend_q    <= clr_pend_d;
            grant_q       <= grant_d;
        end
    end

    assign bus.ACK         = ack_q;
    assign bus.CLR_ACK     = clr_ack_q;
    assign bus.LATCH_CLK   = latch_clk_q;
    assign bus.LATCH_CLR_N = latch_clr_n_q;
    assign bus.LATCH_D     = latch_d_q;
    assign bus.SHADOW_Q    = shadow_q;
    assign bus.BUSY        = busy_q;

endmodule

// File: tb/tb_quad_latch_scheduler.sv
// Scoreboard bench for quad_latch_scheduler: expected acknowledges are queued
// when requests are driven and compared when the scheduler acknowledges.
module tb_quad_latch_scheduler;
    import quad_latch_pkg::*;

    typedef struct packed {
        logic [1:0] ack;
        logic       clr;
        logic [3:0] shadow;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    quad_latch_scheduler_if bus ();

    quad_latch_scheduler #(.PULSE_LEN(2), .CLR_LEN(2)) dut (
        .CLK_DRV (clk),
        .RESET   (rst),
        .bus     (bus)
    );

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    exp_t        sb[$];
    exp_t        e;
    logic        last_m  = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference arbitration: sole requester wins, tie goes to the one not granted last.
    task automatic push_load(input logic [1:0] r, input logic [3:0] d0, input logic [3:0] d1);
        logic g;
        g      = (r == 2'b11) ? ~last_m : r[1];
        last_m = g;
        sb.push_back('{ack: (g ? 2'b10 : 2'b01), clr: 1'b0, shadow: (g ? d1 : d0)});
    endtask

    task automatic push_clr();
        sb.push_back('{ack: 2'b00, clr: 1'b1, shadow: 4'h0});
    endtask

    task automatic serve(input int unsigned budget);
        int unsigned n = 0;
        while ((bus.REQ != 2'b00 || bus.CLR_REQ || bus.BUSY) && n < budget) begin
            @(negedge clk);
            n++;
            if (bus.CLR_ACK) bus.CLR_REQ = 1'b0;
            if (bus.ACK != 2'b00) bus.REQ = bus.REQ & ~bus.ACK;
        end
        check_eq("serve_timeout", {31'b0, (bus.REQ != 2'b00 || bus.CLR_REQ || bus.BUSY)}, 0);
    endtask

    task automatic wait_latch_clk(input int unsigned budget);
        int unsigned n = 0;
        while (!bus.LATCH_CLK && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("latch_clk_timeout", {31'b0, bus.LATCH_CLK}, 1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check_eq("ack_excl", {31'b0, ($countones({bus.ACK, bus.CLR_ACK}) > 1)}, 0);
            check_eq("clk_clr_excl", {31'b0, bus.LATCH_CLK & ~bus.LATCH_CLR_N}, 0);
            if (bus.ACK != 2'b00 || bus.CLR_ACK) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_ack", {29'b0, bus.ACK, bus.CLR_ACK}, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("ack", {30'b0, bus.ACK}, {30'b0, e.ack});
                    check_eq("clr_ack", {31'b0, bus.CLR_ACK}, {31'b0, e.clr});
                    check_eq("shadow_at_ack", {28'b0, bus.SHADOW_Q}, {28'b0, e.shadow});
                end
            end
        end
    end

    initial begin
        int unsigned hits;
        int unsigned n;
        bus.REQ     = 2'b00;
        bus.DATA0   = 4'h0;
        bus.DATA1   = 4'h0;
        bus.CLR_REQ = 1'b0;

        // Reset values, then power-on clear without CLR_ACK.
        repeat (3) @(negedge clk);
        check_eq("rst_clr_n", {31'b0, bus.LATCH_CLR_N}, 0);
        check_eq("rst_latch_clk", {31'b0, bus.LATCH_CLK}, 0);
        check_eq("rst_latch_d", {28'b0, bus.LATCH_D}, 0);
        check_eq("rst_shadow", {28'b0, bus.SHADOW_Q}, 0);
        check_eq("rst_ack", {29'b0, bus.ACK, bus.CLR_ACK}, 0);
        check_eq("rst_busy", {31'b0, bus.BUSY}, 1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("poc_clr_n_low", {31'b0, bus.LATCH_CLR_N}, 0);
        check_eq("poc_busy", {31'b0, bus.BUSY}, 1);
        @(negedge clk);
        check_eq("poc_clr_n_high", {31'b0, bus.LATCH_CLR_N}, 1);
        check_eq("poc_idle", {31'b0, bus.BUSY}, 0);
        check_eq("poc_no_clr_ack", {31'b0, bus.CLR_ACK}, 0);
        check_eq("poc_shadow", {28'b0, bus.SHADOW_Q}, 0);

        // Both requesters held: grants alternate 0,1,0,1 starting from reset.
        bus.DATA0 = 4'h3;
        bus.DATA1 = 4'hC;
        bus.REQ   = 2'b11;
        repeat (4) push_load(2'b11, 4'h3, 4'hC);
        hits = 0;
        n    = 0;
        while (hits < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.ACK != 2'b00) hits++;
        end
        check_eq("rr_timeout", hits, 4);
        bus.REQ = 2'b00;
        serve(20);

        // Single load with cycle-accurate timing; DATA change after grant is ignored.
        bus.DATA0 = 4'hA;
        bus.REQ   = 2'b01;
        push_load(2'b01, 4'hA, 4'h0);
        @(negedge clk);
        check_eq("t1_latch_d", {28'b0, bus.LATCH_D}, 32'hA);
        check_eq("t1_latch_clk", {31'b0, bus.LATCH_CLK}, 0);
        check_eq("t1_busy", {31'b0, bus.BUSY}, 1);
        bus.DATA0 = 4'h5;
        @(negedge clk);
        check_eq("t2_latch_clk", {31'b0, bus.LATCH_CLK}, 1);
        check_eq("t2_shadow", {28'b0, bus.SHADOW_Q}, 32'hA);
        @(negedge clk);
        check_eq("t3_latch_clk", {31'b0, bus.LATCH_CLK}, 1);
        check_eq("t3_ack", {30'b0, bus.ACK}, 0);
        @(negedge clk);
        check_eq("t4_latch_clk", {31'b0, bus.LATCH_CLK}, 0);
        check_eq("t4_ack", {30'b0, bus.ACK}, 1);
        check_eq("t4_latch_d", {28'b0, bus.LATCH_D}, 32'hA);
        bus.REQ = 2'b00;
        @(negedge clk);
        check_eq("t5_idle", {31'b0, bus.BUSY}, 0);
        check_eq("t5_shadow", {28'b0, bus.SHADOW_Q}, 32'hA);

        // Clear and load raised together: clear first.
        bus.DATA1   = 4'h7;
        bus.CLR_REQ = 1'b1;
        bus.REQ     = 2'b10;
        push_clr();
        push_load(2'b10, 4'h5, 4'h7);
        serve(60);

        // Clear raised during PULSE does not abort the load.
        bus.DATA0 = 4'h5;
        bus.REQ   = 2'b01;
        push_load(2'b01, 4'h5, 4'h7);
        wait_latch_clk(10);
        bus.CLR_REQ = 1'b1;
        push_clr();
        serve(60);
        check_eq("clr_after_load_shadow", {28'b0, bus.SHADOW_Q}, 0);

        // Reset during PULSE aborts the load and repeats the power-on clear.
        bus.DATA0 = 4'h9;
        bus.REQ   = 2'b01;
        wait_latch_clk(10);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_latch_clk", {31'b0, bus.LATCH_CLK}, 0);
        check_eq("mid_rst_clr_n", {31'b0, bus.LATCH_CLR_N}, 0);
        check_eq("mid_rst_ack", {30'b0, bus.ACK}, 0);
        check_eq("mid_rst_busy", {31'b0, bus.BUSY}, 1);
        bus.REQ = 2'b00;
        rst     = 1'b0;
        last_m  = 1'b1;
        @(negedge clk);
        check_eq("mid_poc_clr_n_low", {31'b0, bus.LATCH_CLR_N}, 0);
        @(negedge clk);
        check_eq("mid_poc_clr_n_high", {31'b0, bus.LATCH_CLR_N}, 1);
        check_eq("mid_poc_idle", {31'b0, bus.BUSY}, 0);
        check_eq("mid_poc_shadow", {28'b0, bus.SHADOW_Q}, 0);

        // After reset the first tie goes to requester 0 again.
        bus.DATA0 = 4'h1;
        bus.DATA1 = 4'h2;
        bus.REQ   = 2'b11;
        push_load(2'b11, 4'h1, 4'h2);
        push_load(2'b10, 4'h1, 4'h2);
        serve(60);

        repeat (2) @(negedge clk);
        check_eq("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
